// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: instruction decode register with register scoreboard, branch hold and flush
package params_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REGISTER_WIDTH = 4;
  localparam int OPCODE_WIDTH = 6;
  localparam int INSTR_WIDTH = 32;
  typedef logic [INSTR_WIDTH-1:0] instruction_t;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW = 6'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT = 6'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE = 6'h06;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 6'h07;
endpackage

module decode_pipe_stage #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int OPCODE_WIDTH = params_pkg::OPCODE_WIDTH,
  parameter int OFFSET_LSB = 14,
  parameter int ZERO_REG_EN = 1,
  parameter int STALL_CNT_WIDTH = 16,
  localparam int NUM_REGS = 2**REGISTER_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic instr_valid_i,
  input  params_pkg::instruction_t instruction_i,
  output logic instr_ready_o,
  output logic dec_valid_o,
  input  logic dec_ready_i,
  output logic [DATA_WIDTH-1:0] offset_sign_extend_o,
  output logic [REGISTER_WIDTH-1:0] reg_a_o,
  output logic is_load_o,
  output logic is_store_o,
  output logic is_branch_o,
  output logic is_jump_o,
  output logic reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0] wr_reg_o,
  output logic [OPCODE_WIDTH-1:0] instr_opcode_o,
  input  logic wb_valid_i,
  input  logic [REGISTER_WIDTH-1:0] wb_reg_i,
  input  logic resolve_i,
  input  logic flush_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
  output logic sb_err_o
);
  localparam int INSTR_WIDTH = $bits(params_pkg::instruction_t);
  localparam int OFF_W = INSTR_WIDTH - OFFSET_LSB;
  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_nxt;
  logic [OPCODE_WIDTH-1:0] op;
  logic [REGISTER_WIDTH-1:0] ra, rd, src;
  logic [DATA_WIDTH-1:0] offset;
  logic is_load, is_store, is_branch, is_jump, wr_en, hazard, accept;
  logic [NUM_REGS-1:0] pend_nxt;
  assign op = instruction_i[OPCODE_WIDTH-1:0];
  assign ra = instruction_i[OPCODE_WIDTH +: REGISTER_WIDTH];
  assign rd = instruction_i[OPCODE_WIDTH+REGISTER_WIDTH +: REGISTER_WIDTH];
  assign offset = {{(DATA_WIDTH-OFF_W){instruction_i[INSTR_WIDTH-1]}}, instruction_i[INSTR_WIDTH-1:OFFSET_LSB]};
  assign is_load = op == params_pkg::OP_LW;
  assign is_store = op == params_pkg::OP_SW;
  assign is_branch = op inside {params_pkg::OP_BEQ, params_pkg::OP_BNE, params_pkg::OP_BLT, params_pkg::OP_BGE};
  assign is_jump = op == params_pkg::OP_JMP;
  assign wr_en = !is_store && !is_branch && !is_jump;
  assign src = is_store ? rd : ra;
  assign hazard = pending_o[src] || (wr_en && pending_o[rd]);
  assign instr_ready_o = rst_ni && (!dec_valid_o || dec_ready_i) && !hazard && state == RUN && !flush_i;
  assign accept = instr_valid_i && instr_ready_o;
  always_comb begin
    state_nxt = (state == RUN) ? ((accept && (is_branch || is_jump)) ? HOLD : RUN)
                               : ((resolve_i || flush_i) ? RUN : HOLD);
  end
  // a flushed bundle that was never consumed gives back its destination reservation
  always_comb begin
    pend_nxt = pending_o;
    if (wb_valid_i) pend_nxt[wb_reg_i] = 1'b0;
    if (flush_i && dec_valid_o && reg_wr_en_o && !dec_ready_i) pend_nxt[wr_reg_o] = 1'b0;
    if (accept && wr_en && !(ZERO_REG_EN != 0 && rd == '0)) pend_nxt[rd] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= RUN;
      dec_valid_o <= 1'b0;
      offset_sign_extend_o <= '0;
      reg_a_o <= '0;
      is_load_o <= 1'b0;
      is_store_o <= 1'b0;
      is_branch_o <= 1'b0;
      is_jump_o <= 1'b0;
      reg_wr_en_o <= 1'b0;
      wr_reg_o <= '0;
      instr_opcode_o <= '0;
      pending_o <= '0;
      stall_cnt_o <= '0;
      sb_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      dec_valid_o <= accept ? 1'b1 : (dec_ready_i || flush_i) ? 1'b0 : dec_valid_o;
      if (accept) begin
        offset_sign_extend_o <= offset;
        reg_a_o <= src;
        is_load_o <= is_load;
        is_store_o <= is_store;
        is_branch_o <= is_branch;
        is_jump_o <= is_jump;
        reg_wr_en_o <= wr_en;
        wr_reg_o <= rd;
        instr_opcode_o <= op;
      end
      pending_o <= pend_nxt;
      if (instr_valid_i && hazard && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + STALL_CNT_WIDTH'(1);
      sb_err_o <= sb_err_o | (wb_valid_i & ~pending_o[wb_reg_i]);
    end
  end
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed checks of decode, scoreboard stalls, branch hold, flush and reset
module tb_decode_pipe_stage;
  logic clk = 0, rst_ni = 0, instr_valid = 0, dec_ready = 0;
  logic [31:0] instr = '0;
  logic wb_valid = 0, resolve = 0, flush = 0;
  logic [3:0] wb_reg = '0;
  logic instr_ready, dec_valid, is_load, is_store, is_branch, is_jump, reg_wr_en, sb_err;
  logic [31:0] offset;
  logic [3:0] reg_a, wr_reg;
  logic [5:0] opcode;
  logic [15:0] pending, stall_cnt;
  int tests = 0, fails = 0;

  decode_pipe_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid), .instruction_i(instr),
    .instr_ready_o(instr_ready), .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .offset_sign_extend_o(offset), .reg_a_o(reg_a), .is_load_o(is_load), .is_store_o(is_store),
    .is_branch_o(is_branch), .is_jump_o(is_jump), .reg_wr_en_o(reg_wr_en), .wr_reg_o(wr_reg),
    .instr_opcode_o(opcode), .wb_valid_i(wb_valid), .wb_reg_i(wb_reg), .resolve_i(resolve),
    .flush_i(flush), .pending_o(pending), .stall_cnt_o(stall_cnt), .sb_err_o(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [17:0] off);
    return {off, rd, ra, op};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick;
    tick;
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_valid", dec_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_err", sb_err, 0);
    rst_ni = 1;
    dec_ready = 1;
    // ADD rd=3 accepted
    instr = mk(6'h00, 4'd3, 4'd1, 18'd0);
    instr_valid = 1;
    #1 check("add_ready", instr_ready, 1);
    tick;
    instr_valid = 0;
    #1;
    check("add_valid", dec_valid, 1);
    check("add_wr_en", reg_wr_en, 1);
    check("add_wr_reg", wr_reg, 3);
    check("add_pending", pending, 16'h0008);
    // LW rd=4 ra=3 stalls four cycles, writeback of r3 in the last
    instr = mk(6'h01, 4'd4, 4'd3, 18'd0);
    instr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wb_valid = (i == 3);
      wb_reg = 4'd3;
      #1 check("lw_stall_ready", instr_ready, 0);
      tick;
    end
    wb_valid = 0;
    #1;
    check("lw_pending_clr", pending, 16'h0000);
    check("lw_stall_cnt", stall_cnt, 4);
    check("lw_ready", instr_ready, 1);
    tick;
    check("lw_valid", dec_valid, 1);
    check("lw_is_load", is_load, 1);
    check("lw_wr_reg", wr_reg, 4);
    check("lw_pending", pending, 16'h0010);
    // ADD rd=5 then SW rd=5 ra=2 offset all ones
    instr = mk(6'h00, 4'd5, 4'd0, 18'd0);
    tick;
    check("add5_pending", pending, 16'h0030);
    instr = mk(6'h02, 4'd5, 4'd2, 18'h3FFFF);
    #1 check("sw_stall0", instr_ready, 0);
    tick;
    wb_valid = 1;
    wb_reg = 4'd5;
    #1 check("sw_stall1", instr_ready, 0);
    tick;
    wb_reg = 4'd4;
    #1 check("sw_ready", instr_ready, 1);
    tick;
    wb_valid = 0;
    instr_valid = 0;
    #1;
    check("sw_is_store", is_store, 1);
    check("sw_wr_en", reg_wr_en, 0);
    check("sw_reg_a", reg_a, 5);
    check("sw_offset", offset, 32'hFFFFFFFF);
    check("sw_pending", pending, 16'h0000);
    check("sw_stall_cnt", stall_cnt, 6);
    // BEQ holds issue until resolve
    instr = mk(6'h03, 4'd2, 4'd1, 18'd4);
    instr_valid = 1;
    tick;
    instr_valid = 0;
    #1;
    check("beq_branch", is_branch, 1);
    check("beq_wr_en", reg_wr_en, 0);
    for (int i = 0; i < 3; i++) begin
      check("beq_hold_ready", instr_ready, 0);
      tick;
    end
    resolve = 1;
    #1 check("beq_resolve_ready", instr_ready, 0);
    tick;
    resolve = 0;
    #1 check("beq_run_ready", instr_ready, 1);
    // ADD rd=7 held then flushed, later writeback is an error
    dec_ready = 0;
    instr = mk(6'h00, 4'd7, 4'd1, 18'd0);
    instr_valid = 1;
    tick;
    instr_valid = 0;
    #1;
    check("fl_valid", dec_valid, 1);
    check("fl_pending", pending, 16'h0080);
    tick;
    check("fl_held_valid", dec_valid, 1);
    check("fl_held_reg", wr_reg, 7);
    check("fl_held_ready", instr_ready, 0);
    flush = 1;
    #1 check("fl_flush_ready", instr_ready, 0);
    tick;
    flush = 0;
    #1;
    check("fl_cleared_valid", dec_valid, 0);
    check("fl_cleared_pending", pending, 16'h0000);
    check("fl_no_err", sb_err, 0);
    wb_valid = 1;
    wb_reg = 4'd7;
    tick;
    wb_valid = 0;
    #1 check("fl_sb_err", sb_err, 1);
    // flush with a completing transfer keeps the reservation
    dec_ready = 1;
    instr = mk(6'h00, 4'd6, 4'd0, 18'd0);
    instr_valid = 1;
    tick;
    instr_valid = 0;
    flush = 1;
    tick;
    flush = 0;
    #1;
    check("fx_valid", dec_valid, 0);
    check("fx_pending", pending, 16'h0040);
    // build pending 0x0F0 then enter HOLD with a held bundle, then reset
    instr_valid = 1;
    instr = mk(6'h00, 4'd4, 4'd0, 18'd0);
    tick;
    instr = mk(6'h00, 4'd5, 4'd0, 18'd0);
    tick;
    instr = mk(6'h00, 4'd7, 4'd0, 18'd0);
    tick;
    instr = mk(6'h03, 4'd0, 4'd0, 18'h20000);
    tick;
    instr_valid = 0;
    dec_ready = 0;
    #1;
    check("rs_pending", pending, 16'h00F0);
    check("rs_hold_ready", instr_ready, 0);
    check("rs_valid", dec_valid, 1);
    rst_ni = 0;
    #1 check("rs_ready_in_rst", instr_ready, 0);
    tick;
    check("rs2_valid", dec_valid, 0);
    check("rs2_pending", pending, 0);
    check("rs2_stall", stall_cnt, 0);
    check("rs2_err", sb_err, 0);
    check("rs2_offset", offset, 0);
    check("rs2_branch", is_branch, 0);
    check("rs2_opcode", opcode, 0);
    rst_ni = 1;
    dec_ready = 1;
    #1 check("rs2_run_ready", instr_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default params_pkg::DATA_WIDTH, operand/offset width.
REQ-002 SHALL have parameter REGISTER_WIDTH, default params_pkg::REGISTER_WIDTH, register index width; register count NUM_REGS = 2**REGISTER_WIDTH.
REQ-003 SHALL have parameter OPCODE_WIDTH, default params_pkg::OPCODE_WIDTH, opcode width.
REQ-004 SHALL have parameter OFFSET_LSB, default 14, lowest instruction bit of the offset field.
REQ-005 SHALL have parameter ZERO_REG_EN, default 1; when 1, register 0 is never marked pending.
REQ-006 SHALL have parameter STALL_CNT_WIDTH, default 16, stall counter width.
REQ-007 SHALL use one clock and a synchronous, active-low reset: clk_i input 1 (clock); rst_ni input 1 (synchronous active-low reset).
REQ-008 SHALL have the following upstream ports: instr_valid_i input 1 (instruction present); instruction_i input instruction_t (fetched instruction); instr_ready_o output 1 (instruction accepted this cycle when both are high).
REQ-009 SHALL have the following downstream ports: dec_valid_o output 1 (decoded bundle valid); dec_ready_i input 1 (consumer takes bundle).
REQ-010 SHALL have the following registered bundle outputs: offset_sign_extend_o DATA_WIDTH; reg_a_o REGISTER_WIDTH; is_load_o 1; is_store_o 1; is_branch_o 1; is_jump_o 1; reg_wr_en_o 1; wr_reg_o REGISTER_WIDTH; instr_opcode_o OPCODE_WIDTH.
REQ-011 SHALL have the following writeback and control ports: wb_valid_i input 1 (register write completes); wb_reg_i input REGISTER_WIDTH (written register); resolve_i input 1 (branch/jump resolved); flush_i input 1 (kill held bundle).
REQ-012 SHALL have the following status ports: pending_o output NUM_REGS (scoreboard); stall_cnt_o output STALL_CNT_WIDTH (hazard-stall cycles); sb_err_o output 1 (sticky scoreboard error).

Function
REQ-013 Decode of instruction_i SHALL be as follows.
- Offset: sign extension of instruction_i[INSTR_WIDTH-1:OFFSET_LSB].
- Source register src: rd if opcode==SW, else ra.
- is_branch: opcode in {BEQ, BNE, BLT, BGE}.
- is_jump: opcode==JMP.
- reg_wr_en: not store, not branch, not jump.
- wr_reg = rd.
REQ-014 The decoded bundle SHALL be captured into the output register on accept; latency is exactly 1 cycle from accept to dec_valid_o=1.
REQ-015 instr_ready_o SHALL be high exactly when all of the following hold: (!dec_valid_o || dec_ready_i), !hazard, state==RUN, !flush_i.
REQ-016 hazard SHALL equal pending_o[src] || (reg_wr_en && pending_o[wr_reg]), evaluated on registered pending_o only; there is no same-cycle writeback bypass.
REQ-017 dec_valid_o SHALL be set on accept, and cleared when dec_ready_i=1 with no accept in the same cycle.
- Bundle and valid SHALL hold stable while dec_valid_o=1 and dec_ready_i=0.
REQ-018 On accept with reg_wr_en=1, pending_o[wr_reg] SHALL set next cycle, except register 0 when ZERO_REG_EN=1.
REQ-019 wb_valid_i SHALL clear pending_o[wb_reg_i] next cycle.
- If that bit is already 0, sb_err_o SHALL set and remain set until reset.
REQ-020 The FSM SHALL have states RUN and HOLD.
- RUN->HOLD on accept of a branch or jump.
- HOLD->RUN on resolve_i or flush_i.
- resolve_i in RUN SHALL be ignored.
REQ-021 flush_i SHALL clear dec_valid_o next cycle.
- If the held bundle has reg_wr_en=1 and has not been taken by dec_ready_i in the flush cycle, its pending bit SHALL also clear.
- flush_i SHALL NOT clear other pending bits.
REQ-022 flush_i concurrent with dec_valid_o && dec_ready_i: the transfer SHALL complete and its pending bit SHALL remain set.
REQ-023 flush_i and wb_valid_i in the same cycle SHALL both take effect.
REQ-024 stall_cnt_o SHALL increment by 1 each cycle instr_valid_i=1 and hazard=1, and SHALL saturate at all-ones.
REQ-025 Clock enables SHALL NOT be gated on clk_i, and no output SHALL be combinationally dependent on dec_ready_i except instr_ready_o.

Reset
REQ-026 While rst_ni=0 at a clk_i edge, the block SHALL reset as follows: state=RUN, dec_valid_o=0, all bundle outputs=0, pending_o=0, stall_cnt_o=0, sb_err_o=0.
REQ-027 Reset mid-operation (HOLD state, pending bits set, bundle held) SHALL discard all state with no further handshake.
REQ-028 instr_ready_o SHALL be 0 while rst_ni=0.

Verification
REQ-029 Bench SHALL cover: ADD rd=3 accepted, dec_ready_i=1 -> dec_valid_o=1 next cycle, reg_wr_en_o=1, wr_reg_o=3, pending_o[3]=1.
REQ-030 Bench SHALL cover: LW ra=3 while pending_o[3]=1 for 4 cycles, then wb_valid_i with wb_reg_i=3 -> instr_ready_o=0 for those cycles, stall_cnt_o=4, accept in the cycle after pending_o[3] clears.
REQ-031 Bench SHALL cover: SW rd=5, ra=2 with pending_o[5]=1 -> stalls; is_store_o=1 and reg_wr_en_o=0 once issued; offset field 0x3FFFF with DATA_WIDTH=32 -> offset_sign_extend_o=0xFFFFFFFF.
REQ-032 Bench SHALL cover: BEQ accepted -> HOLD, instr_ready_o=0 until resolve_i pulse, then instr_ready_o=1 the following cycle.
REQ-033 Bench SHALL cover: ADD rd=7 held with dec_ready_i=0, then flush_i -> dec_valid_o=0 and pending_o[7]=0 next cycle; wb_valid_i with wb_reg_i=7 afterwards -> sb_err_o=1.
REQ-034 Bench SHALL cover: rst_ni=0 asserted in HOLD with pending_o=0x0F0 -> all outputs 0, state RUN after the reset edge.
